// File: rtl/layer_io_pkg.sv
// -----------------------------------------------------------------------------
// layer_io_pkg
// Shared types and defaults for the layer I/O master and its serializer.
//   layer_io_state_t : transaction FSM states
//   DEF_N/DEF_M/DEF_T: default vector length, result count, element width
//   elem_t           : signed element of the default width
//   idx_width()      : index counter width covering both N and M, plus one bit
// -----------------------------------------------------------------------------
package layer_io_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_M = 4;
  localparam int DEF_T = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } layer_io_state_t;

  typedef logic signed [DEF_T-1:0] elem_t;

  function automatic int idx_width(input int n, input int m);
    return $clog2((n > m) ? n : m) + 1;
  endfunction

endpackage

// File: rtl/layer_io_serializer.sv
// -----------------------------------------------------------------------------
// layer_io_serializer
// Holds the N-entry input buffer and walks it onto the layer's input stream.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : latch vec_in into the buffer and restart the index
//   vec_in      : packed input vector, element k at [k*T +: T]
//   send_en     : master is in its SEND phase
//   l_ready     : layer accepts the current element
//   l_valid     : element on l_data is offered to the layer
//   l_data      : current element (zero outside SEND)
//   last_xfer   : the N-th element is transferred on this edge
// -----------------------------------------------------------------------------
module layer_io_serializer
  import layer_io_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int T  = DEF_T,
  parameter int IW = idx_width(DEF_N, DEF_M)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [N*T-1:0] vec_in,
  input  logic           send_en,
  input  logic           l_ready,
  output logic           l_valid,
  output logic [T-1:0]   l_data,
  output logic           last_xfer
);

  logic [T-1:0]  vec_buf [N];
  logic [IW-1:0] idx_reg;
  logic          xfer;

  assign xfer      = send_en && l_ready;
  assign last_xfer = xfer && (idx_reg == IW'(N - 1));
  // Valid is a plain decode of the phase, so it is up before the layer
  // raises ready and cannot drop while the layer stalls.
  assign l_valid   = send_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) vec_buf[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < N; k++) vec_buf[k] <= vec_in[k*T +: T];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg <= '0;
    end else if (load) begin
      idx_reg <= '0;
    end else if (xfer) begin
      idx_reg <= last_xfer ? '0 : idx_reg + IW'(1);
    end
  end

  // Compare-based mux so the index never has to be sliced to the buffer depth.
  always_comb begin
    l_data = '0;
    if (send_en) begin
      for (int k = 0; k < N; k++) begin
        if (idx_reg == IW'(k)) l_data = vec_buf[k];
      end
    end
  end

endmodule

// File: rtl/layer_io_master.sv
// -----------------------------------------------------------------------------
// layer_io_master
// Drives one transaction through a layer block: serializes an N-element
// vector onto the layer input stream, collects M results from the layer
// output stream, then presents them as a packed word with a done pulse.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start, vec_in    : begin a transaction with this vector (IDLE only)
//   busy, done       : not idle / one-cycle result-valid pulse
//   result           : packed results, held until the next done
//   txn_cnt          : completed transactions (wraps)
//   proto_err        : sticky handshake-violation flag
//   l_valid/l_ready/l_data : layer input stream
//   r_valid/r_ready/r_data : layer output stream
// -----------------------------------------------------------------------------
module layer_io_master
  import layer_io_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M,
  parameter int T = DEF_T
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N*T-1:0] vec_in,
  output logic           busy,
  output logic           done,
  output logic [M*T-1:0] result,
  output logic [15:0]    txn_cnt,
  output logic           proto_err,
  output logic           l_valid,
  input  logic           l_ready,
  output logic [T-1:0]   l_data,
  input  logic           r_valid,
  output logic           r_ready,
  input  logic [T-1:0]   r_data
);

  localparam int IW = idx_width(N, M);

  layer_io_state_t state_reg, state_next;

  logic           load;
  logic           send_en;
  logic           last_send;
  logic           r_xfer;
  logic           last_recv;
  logic           bad_handshake;
  logic [IW-1:0]  ridx_reg;
  logic [M*T-1:0] res_reg;
  logic [M*T-1:0] res_next;

  layer_io_serializer #(
    .N  (N),
    .T  (T),
    .IW (IW)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .vec_in    (vec_in),
    .send_en   (send_en),
    .l_ready   (l_ready),
    .l_valid   (l_valid),
    .l_data    (l_data),
    .last_xfer (last_send)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = SEND;
      SEND:    if (last_send) state_next = RECV;
      RECV:    if (last_recv) state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg != IDLE);
    done    = (state_reg == DONE);
    r_ready = (state_reg == RECV);
    send_en = (state_reg == SEND);
    load    = (state_reg == IDLE) && start;
  end

  // ---------------------------------------------------------- collector
  assign r_xfer    = r_ready && r_valid;
  assign last_recv = r_xfer && (ridx_reg == IW'(M - 1));

  // Results arriving from the layer while we are not listening, or the layer
  // still asking for input after it has had all N elements.
  assign bad_handshake = (r_valid && (state_reg == SEND || state_reg == IDLE)) ||
                         (l_ready && state_reg == RECV);

  // res_next already contains the element landing on this edge, so result
  // can be loaded on the final receive edge and be valid during done.
  for (genvar gi = 0; gi < M; gi++) begin : g_res
    assign res_next[gi*T +: T] = (r_xfer && ridx_reg == IW'(gi)) ? r_data
                                                                  : res_reg[gi*T +: T];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ridx_reg  <= '0;
      res_reg   <= '0;
      result    <= '0;
      txn_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (load) begin
        ridx_reg <= '0;
      end else if (r_xfer) begin
        ridx_reg <= ridx_reg + IW'(1);
        res_reg  <= res_next;
      end
      if (last_recv) begin
        result  <= res_next;
        txn_cnt <= txn_cnt + 16'd1;
      end
      if (bad_handshake) proto_err <= 1'b1;
    end
  end

endmodule
